// File: rtl/alu_sequencer.sv
// Command sequencer that drives an external 5-bit combinational ALU. It holds the
// accumulator and flags, and builds a 5-step shift-add multiply out of ALU adds.
module alu_sequencer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_code,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] acc,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             rsp_valid,
    output logic             rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    localparam logic [3:0] C_LOAD  = 4'b1000;
    localparam logic [3:0] C_MUL   = 4'b1001;
    localparam logic [3:0] C_CLEAR = 4'b1010;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_code;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_m;
    logic             r_ovf;
    logic [2:0]       r_step;
    logic             w_accept;
    logic             w_last;
    logic             w_ovf_next;

    // Bits shifted out of the multiplicand still matter if any multiplier bits remain.
    function automatic logic mul_lost_bit(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] m);
        return mc[WIDTH-1] && ((m >> 1) != '0);
    endfunction

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_last     = (r_step == 3'd4);
    assign w_ovf_next = r_ovf || alu_carry || mul_lost_bit(r_mc, r_m);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (cmd_code == C_MUL) ? S_MUL : S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_MUL:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_DONE);
        rsp_err   = (r_state == S_DONE) && r_err;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = 3'b000;
        if (r_state == S_EXEC && !r_code[3]) begin
            alu_a  = r_acc;
            alu_b  = r_data;
            alu_op = r_code[2:0];
        end else if (r_state == S_MUL) begin
            alu_a  = r_p;
            alu_b  = r_m[0] ? r_mc : '0;
            alu_op = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_step  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_step <= 3'd0;
                    r_ovf  <= 1'b0;
                end
                S_EXEC: begin
                    r_err <= r_code[3] && (r_code[2:0] > 3'd2);
                    if (!r_code[3]) begin
                        r_acc   <= alu_result;
                        r_carry <= alu_carry;
                        r_zero  <= alu_zero;
                    end else if (r_code == C_LOAD) begin
                        r_acc   <= r_data;
                        r_carry <= 1'b0;
                        r_zero  <= (r_data == '0);
                    end else if (r_code == C_CLEAR) begin
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_zero  <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_step <= r_step + 3'd1;
                    r_ovf  <= w_ovf_next;
                    if (w_last) begin
                        r_acc   <= alu_result;
                        r_carry <= w_ovf_next;
                        r_zero  <= (alu_result == '0);
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and multiply working registers need no reset: they are loaded on every accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_code <= cmd_code;
            r_data <= cmd_data;
            r_p    <= '0;
            r_mc   <= r_acc;
            r_m    <= cmd_data;
        end else if (r_state == S_MUL) begin
            r_p  <= alu_result;
            r_mc <= r_mc << 1;
            r_m  <= r_m >> 1;
        end
    end

    assign acc        = r_acc;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: provides the combinational ALU and checks results, flags,
// latency and handshake against an arithmetic reference model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_code;
    logic [4:0] cmd_data;
    logic [4:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_carry, alu_zero;
    logic [4:0] acc;
    logic       carry_flag, zero_flag, rsp_valid, rsp_err;

    int total = 0;
    int bad   = 0;

    logic [4:0] m_acc;
    logic       m_c, m_z;

    typedef struct {
        logic [3:0] code;
        logic [4:0] data;
        logic [4:0] acc;
        logic       c;
        logic       z;
        logic       err;
        int         lat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_data(cmd_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .acc(acc), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .rsp_valid(rsp_valid), .rsp_err(rsp_err)
    );

    // ALU: {carry, result}
    function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: return 6'(ia + ib);
            3'd1: return {(ia < ib), 5'(ia - ib)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a[4], a[3:0], 1'b0};
            default: begin
                r = ia / 2;
                return {a[0], 5'(r)};
            end
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero = (alu_result == 5'd0);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input logic [3:0] code, input logic [4:0] data, output logic err);
        logic [5:0] cr;
        int prod;
        err = 1'b0;
        if (!code[3]) begin
            cr = alu_f(code[2:0], m_acc, data);
            m_acc = cr[4:0];
            m_c = cr[5];
            m_z = (cr[4:0] == 5'd0);
        end else begin
            case (code)
                4'h8: begin m_acc = data; m_c = 1'b0; m_z = (data == 5'd0); end
                4'h9: begin
                    prod = int'(m_acc) * int'(data);
                    m_acc = 5'(prod % 32);
                    m_c = (prod > 31);
                    m_z = (m_acc == 5'd0);
                end
                4'hA: begin m_acc = 5'd0; m_c = 1'b0; m_z = 1'b1; end
                default: err = 1'b1;
            endcase
        end
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] code, input logic [4:0] data,
                           input logic [4:0] e_acc, input logic e_c, input logic e_z,
                           input logic e_err, input int e_lat);
        int n;
        int lat;
        logic busy_ok;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s.accept", tag), int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!rsp_valid && lat < 20) begin
            if (cmd_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (cmd_ready) busy_ok = 1'b0;
        chk($sformatf("%s.lat", tag), lat, e_lat);
        chk($sformatf("%s.acc", tag), int'(acc), int'(e_acc));
        chk($sformatf("%s.carry", tag), int'(carry_flag), int'(e_c));
        chk($sformatf("%s.zero", tag), int'(zero_flag), int'(e_z));
        chk($sformatf("%s.err", tag), int'(rsp_err), int'(e_err));
        chk($sformatf("%s.busy_ready", tag), int'(busy_ok), 1);
        @(negedge clk);
        chk($sformatf("%s.pulse", tag), int'({rsp_valid, cmd_ready}), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic err;
        int accepts, rsps, overlap;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_code = 4'h0;
        cmd_data = 5'd0;
        repeat (2) @(negedge clk);
        chk("reset.acc", int'(acc), 0);
        chk("reset.carry", int'(carry_flag), 0);
        chk("reset.zero", int'(zero_flag), 1);
        chk("reset.rsp", int'({rsp_valid, rsp_err}), 0);
        chk("reset.ready", int'(cmd_ready), 1);
        chk("reset.alu", int'({alu_a, alu_b, alu_op}), 0);
        rst = 1'b0;

        tbl.push_back('{4'h8, 5'd20, 5'd20, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h0, 5'd15, 5'd3,  1'b1, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h8, 5'd9,  5'd9,  1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h1, 5'd9,  5'd0,  1'b0, 1'b1, 1'b0, 2});
        tbl.push_back('{4'h8, 5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h5, 5'd0,  5'd26, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h8, 5'd6,  5'd6,  1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h9, 5'd5,  5'd30, 1'b0, 1'b0, 1'b0, 6});
        tbl.push_back('{4'h8, 5'd8,  5'd8,  1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h9, 5'd4,  5'd0,  1'b1, 1'b1, 1'b0, 6});
        tbl.push_back('{4'h8, 5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'hC, 5'd3,  5'd7,  1'b0, 1'b0, 1'b1, 2});
        tbl.push_back('{4'h8, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h0, 5'd1,  5'd0,  1'b1, 1'b1, 1'b0, 2});
        tbl.push_back('{4'hB, 5'd9,  5'd0,  1'b1, 1'b1, 1'b1, 2});
        tbl.push_back('{4'h8, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h9, 5'd31, 5'd1,  1'b1, 1'b0, 1'b0, 6});
        tbl.push_back('{4'hA, 5'd17, 5'd0,  1'b0, 1'b1, 1'b0, 2});
        tbl.push_back('{4'h8, 5'd3,  5'd3,  1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{4'h9, 5'd7,  5'd21, 1'b0, 1'b0, 1'b0, 6});
        for (int i = 0; i < tbl.size(); i++)
            run_cmd($sformatf("vec%0d", i), tbl[i].code, tbl[i].data,
                    tbl[i].acc, tbl[i].c, tbl[i].z, tbl[i].err, tbl[i].lat);
        m_acc = 5'd21;
        m_c = 1'b0;
        m_z = 1'b0;

        for (int i = 0; i < 150; i++) begin
            logic [3:0] code;
            logic [4:0] data;
            code = 4'($urandom_range(0, 15));
            data = 5'($urandom_range(0, 31));
            model(code, data, err);
            run_cmd($sformatf("rnd%0d", i), code, data, m_acc, m_c, m_z, err,
                    (code == 4'h9) ? 6 : 2);
        end

        run_cmd("b2b.clear", 4'hA, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2);
        accepts = 0;
        rsps = 0;
        overlap = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_code = 4'h0;
        cmd_data = 5'd1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_valid) rsps++;
            if (cmd_ready) accepts++;
            if (rsp_valid && cmd_ready) overlap++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) rsps++;
        end
        chk("b2b.accepts", accepts, 10);
        chk("b2b.rsps", rsps, 10);
        chk("b2b.overlap", overlap, 0);
        chk("b2b.acc", int'(acc), 10);
        chk("b2b.flags", int'({carry_flag, zero_flag}), 0);

        run_cmd("rst.load", 4'h8, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_code = 4'h9;
        cmd_data = 5'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst.ready", int'(cmd_ready), 1);
        chk("rst.acc", int'(acc), 0);
        chk("rst.zero", int'(zero_flag), 1);
        chk("rst.carry", int'(carry_flag), 0);
        #2 rst = 1'b0;
        rsps = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) rsps++;
        end
        chk("rst.no_rsp", rsps, 0);
        run_cmd("rst.after", 4'h0, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
